// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch queue.
package instr_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h3000_0000;
    localparam logic [3:0]  HALT_OPC  = 4'hF;
    localparam int          OPC_MSB   = 31;
    localparam int          OPC_LSB   = 28;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

    function automatic logic is_halt(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB] == HALT_OPC;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small circular-buffer FIFO with synchronous clear; head entry is
// combinationally visible, so a write becomes readable after the edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop    = pop && !clear && (count != '0);
    assign do_push   = push && !clear && ((count != FULL_COUNT) || do_pop);
    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);

    // Storage array: written on push, no reset needed since count guards reads
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; clear empties the queue in one edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetcher: credit-limited memory requests, in-order response
// queue, redirect with stale-response dropping, and a sticky halt.
module instr_fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_STEP  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            isstall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o,
    output logic            halted_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic            halted;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] head_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_after_resp;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   queue_count;
    logic [CW:0]     credit_sum;

    logic [XLEN-1:0] fifo_head;
    logic            fifo_empty;

    logic            issue;
    logic            pop;
    logic            push;
    logic            halt_pop;
    logic            redirect_take;
    logic            resp_retire;
    logic            flush;

    assign credit_sum  = {1'b0, queue_count} + {1'b0, outstanding};
    assign mem_req_o   = !rst && !halted && !redirect_i && (credit_sum < CREDIT_LIMIT);
    assign mem_addr_o  = fetch_pc;
    assign issue       = mem_req_o && mem_gnt_i;

    assign instr_valid_o = !rst && !fifo_empty && !isstall_i && !redirect_i && !halted;
    assign pop           = instr_valid_o;
    assign instr_o       = instr_valid_o ? fifo_head : XLEN'(NOP_INSTR);
    assign instr_pc_o    = head_pc;
    assign halted_o      = halted;

    // A redirect coinciding with a halt pop loses; halting always wins.
    assign halt_pop      = pop && is_halt(fifo_head[31:0]);
    assign redirect_take = redirect_i && !halted && !halt_pop;
    assign flush         = redirect_take || halt_pop;

    // Any response retires an in-flight request; only fresh ones while running get queued.
    assign resp_retire            = mem_rvalid_i && (outstanding != '0);
    assign outstanding_after_resp = outstanding - CW'(resp_retire);
    assign push                   = resp_retire && (drop_cnt == '0) && !halted;

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push),
        .push_data (mem_rdata_i),
        .pop       (pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (queue_count)
    );

    // Run/halt state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Delivering a halt instruction parks the fetcher until reset
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && halt_pop) begin
            state_d = ST_HALTED;
        end
    end

    // Halted flag decoded from state
    always_comb begin
        halted = 1'b0;
        if (state_q == ST_HALTED) begin
            halted = 1'b1;
        end
    end

    // Fetch and head program counters follow issues, pops and redirects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
        end else if (redirect_take) begin
            fetch_pc <= redirect_pc_i;
            head_pc  <= redirect_pc_i;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + STEP;
            end
            if (pop) begin
                head_pc <= head_pc + STEP;
            end
        end
    end

    // In-flight request count and number of stale responses still to discard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_after_resp + CW'(issue);
            if (redirect_take) begin
                drop_cnt <= outstanding_after_resp;
            end else if (resp_retire && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed and randomised bench for instr_fetch_queue with an in-order
// memory model and a delivered-stream scoreboard.
module tb_instr_fetch_queue;

    localparam logic [31:0] NOP = 32'h3000_0000;

    logic        clk;
    logic        rst;
    logic        isstall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        halted_o;

    instr_fetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .PC_STEP  (1),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .isstall_i     (isstall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .halted_o      (halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } pend_t;

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    pend_t       pend_q[$];
    vec_t        vecs[12];

    int          n_checks;
    int          n_pass;
    int          cyc;
    int          last_ready;
    int          lat_min;
    int          lat_max;
    int          gnt_mode;
    int          delivered;
    int          issued;
    bit          halt_mode;
    bit          stray_pending;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [31:0] s_pc;
    logic        s_halted;

    // Instruction memory contents; word 5 becomes a halt in the halt test
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_mode && a == 32'd5) begin
            return 32'hF000_0000;
        end
        return {4'h2, 8'hA5, a[19:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle from a negedge, sample outputs, run the memory model
    // and scoreboard, then advance to the next negedge.
    task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] target);
        pend_t p;
        int    lat;
        int    rdy;
        isstall_i     = stall;
        redirect_i    = redir;
        redirect_pc_i = target;
        case (gnt_mode)
            0:       mem_gnt_i = 1'b0;
            1:       mem_gnt_i = 1'b1;
            default: mem_gnt_i = ($urandom_range(0, 2) != 0);
        endcase
        if (stray_pending) begin
            mem_rvalid_i  = 1'b1;
            mem_rdata_i   = 32'hDEAD_BEEF;
            stray_pending = 1'b0;
        end else if (pend_q.size() != 0 && pend_q[0].ready <= cyc) begin
            p            = pend_q.pop_front();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(p.addr);
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
        end
        #1;
        s_req    = mem_req_o;
        s_addr   = mem_addr_o;
        s_valid  = instr_valid_o;
        s_instr  = instr_o;
        s_pc     = instr_pc_o;
        s_halted = halted_o;
        if (mem_req_o && mem_gnt_i) begin
            checkOutput("issue_addr", mem_addr_o, exp_fetch);
            exp_fetch = exp_fetch + 32'd1;
            issued++;
            lat = $urandom_range(lat_min, lat_max);
            rdy = cyc + lat;
            if (rdy <= last_ready) begin
                rdy = last_ready + 1;
            end
            last_ready = rdy;
            p.addr  = mem_addr_o;
            p.ready = rdy;
            pend_q.push_back(p);
        end
        if (instr_valid_o) begin
            checkOutput("deliver_pc", instr_pc_o, exp_pc);
            checkOutput("deliver_instr", instr_o, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd1;
            delivered++;
        end
        if (redir && !s_halted) begin
            exp_pc    = target;
            exp_fetch = target;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Hold reset for two edges, checking the held outputs, then release at a negedge
    task automatic applyReset();
        rst           = 1'b1;
        isstall_i     = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        mem_gnt_i     = 1'b1;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = 32'h0;
        #2;
        checkOutput("rst_mem_req", mem_req_o, 32'd0);
        checkOutput("rst_valid", instr_valid_o, 32'd0);
        checkOutput("rst_halted", halted_o, 32'd0);
        checkOutput("rst_instr", instr_o, NOP);
        checkOutput("rst_pc", instr_pc_o, 32'h0);
        checkOutput("rst_addr", mem_addr_o, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pend_q.delete();
        last_ready = -1;
        cyc        = 0;
        exp_pc     = 32'h0;
        exp_fetch  = 32'h0;
        delivered  = 0;
        issued     = 0;
    endtask

    initial begin
        bit found;
        int snap;

        n_checks      = 0;
        n_pass        = 0;
        halt_mode     = 1'b0;
        stray_pending = 1'b0;
        gnt_mode      = 1;
        lat_min       = 1;
        lat_max       = 1;

        vecs[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0, NOP};
        vecs[1]  = '{1'b0, 1'b1, 32'd1,  1'b0, 32'd0, NOP};
        vecs[2]  = '{1'b0, 1'b1, 32'd2,  1'b1, 32'd0, mem_word(32'd0)};
        vecs[3]  = '{1'b0, 1'b1, 32'd3,  1'b1, 32'd1, mem_word(32'd1)};
        vecs[4]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd2, mem_word(32'd2)};
        vecs[5]  = '{1'b0, 1'b1, 32'd5,  1'b1, 32'd3, mem_word(32'd3)};
        vecs[6]  = '{1'b1, 1'b1, 32'd6,  1'b0, 32'd4, NOP};
        vecs[7]  = '{1'b1, 1'b1, 32'd7,  1'b0, 32'd4, NOP};
        vecs[8]  = '{1'b0, 1'b0, 32'd8,  1'b1, 32'd4, mem_word(32'd4)};
        vecs[9]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd5, mem_word(32'd5)};
        vecs[10] = '{1'b0, 1'b1, 32'd9,  1'b1, 32'd6, mem_word(32'd6)};
        vecs[11] = '{1'b0, 1'b1, 32'd10, 1'b1, 32'd7, mem_word(32'd7)};

        // Startup stream with a stray pre-reset response and a short stall
        applyReset();
        stray_pending = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].stall, 1'b0, 32'h0);
            checkOutput($sformatf("vec%0d_req", i), s_req, vecs[i].exp_req);
            checkOutput($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d_valid", i), s_valid, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d_pc", i), s_pc, vecs[i].exp_pc);
            checkOutput($sformatf("vec%0d_instr", i), s_instr, vecs[i].exp_instr);
        end

        // Long stall: credits fill, then four back-to-back deliveries
        applyReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
        end
        checkOutput("stall_inflight", issued - delivered, 32'd4);
        checkOutput("stall_req", s_req, 32'd0);
        checkOutput("stall_instr", s_instr, NOP);
        checkOutput("stall_valid", s_valid, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput($sformatf("release%0d_valid", i), s_valid, 32'd1);
            checkOutput($sformatf("release%0d_pc", i), s_pc, i);
        end

        // Redirect with responses still in flight
        applyReset();
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        applyStimulus(1'b0, 1'b1, 32'h100);
        checkOutput("redir_req", s_req, 32'd0);
        checkOutput("redir_valid", s_valid, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            if (s_valid) begin
                found = 1'b1;
                checkOutput("redir_first_pc", s_pc, 32'h100);
                checkOutput("redir_first_instr", s_instr, mem_word(32'h100));
            end
        end
        checkOutput("redir_delivery_seen", found, 32'd1);

        // Halt instruction at address 5
        applyReset();
        lat_min   = 1;
        lat_max   = 1;
        halt_mode = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            if (s_valid && s_pc == 32'd5) begin
                found = 1'b1;
                checkOutput("halt_instr", s_instr, 32'hF000_0000);
                checkOutput("halt_not_yet", s_halted, 32'd0);
            end
        end
        checkOutput("halt_seen", found, 32'd1);
        snap = delivered;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, (i == 2 || i == 3), 32'h40);
            checkOutput($sformatf("halted%0d", i), s_halted, 32'd1);
            checkOutput($sformatf("halted%0d_req", i), s_req, 32'd0);
            checkOutput($sformatf("halted%0d_valid", i), s_valid, 32'd0);
            checkOutput($sformatf("halted%0d_instr", i), s_instr, NOP);
        end
        checkOutput("halt_no_more", delivered - snap, 32'd0);
        halt_mode = 1'b0;

        // Random grants, latencies, stalls and occasional redirects
        applyReset();
        gnt_mode = 2;
        lat_min  = 1;
        lat_max  = 5;
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 59) == 0,
                          32'h400 + $urandom_range(0, 255));
        end
        gnt_mode = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        checkOutput("random_progress", delivered >= 100, 32'd1);
        checkOutput("random_all_delivered", exp_pc, exp_fetch);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
